// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the two-requester ROM arbiter.
package rom_arb_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 3;

   typedef enum logic {
      IDLE,
      READ
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/rom_arbiter2.sv
// Shares one asynchronous ROM between two requesters; each accepted read
// takes one READ cycle and returns a one-cycle response pulse.
module rom_arbiter2
   import rom_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   output logic                  req0_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_data,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   output logic                  req1_ready,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_data,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic                  busy
);

   state_t     state;
   logic       owner;
   logic       last_grant;
   logic [1:0] gnt;
   logic       accept_en;

   rr_arbiter2 u_rr_arbiter2 (
      .req        ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .gnt        (gnt)
   );

   // Ready is held low while reset is asserted so no handshake is seen then.
   assign accept_en  = (state == IDLE) && !rst;
   assign req0_ready = accept_en && gnt[0];
   assign req1_ready = accept_en && gnt[1];
   assign busy       = (state == READ);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rom_addr   <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt != 2'b00) begin
                  rom_addr   <= gnt[1] ? req1_addr : req0_addr;
                  owner      <= gnt[1];
                  last_grant <= gnt[1];
                  state      <= READ;
               end
            end
            READ: begin
               if (owner) begin
                  rsp1_data  <= rom_q;
                  rsp1_valid <= 1'b1;
               end else begin
                  rsp0_data  <= rom_q;
                  rsp0_valid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_arbiter2.sv
// Bench for rom_arbiter2: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_rom_arbiter2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic [2:0] req0_addr = 3'd0;
   logic       req0_ready;
   logic       rsp0_valid;
   logic [7:0] rsp0_data;
   logic       req1_valid = 1'b0;
   logic [2:0] req1_addr = 3'd0;
   logic       req1_ready;
   logic       rsp1_valid;
   logic [7:0] rsp1_data;
   logic [2:0] rom_addr;
   logic [7:0] rom_q;
   logic       busy;

   logic [7:0] rom [8];
   assign rom_q = rom[rom_addr];

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

   rom_arbiter2 #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_ready (req0_ready),
      .rsp0_valid (rsp0_valid),
      .rsp0_data  (rsp0_data),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_ready (req1_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_data  (rsp1_data),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: who wins now, what is in flight, what each
   // requester last received.
   function automatic int winner(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return last ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   logic       m_busy;
   int         m_owner;
   logic       m_last;
   logic [2:0] m_rom_addr;
   logic       m_rsp_valid [2];
   logic [7:0] m_rsp_data [2];
   int         m_win;
   bit         acc0, acc1;

   always_comb m_win = (m_busy || rst) ? -1 : winner(req0_valid, req1_valid, m_last);

   always @(posedge clk) begin
      acc0 <= 1'b0;
      acc1 <= 1'b0;
      m_rsp_valid[0] <= 1'b0;
      m_rsp_valid[1] <= 1'b0;
      if (rst) begin
         m_busy        <= 1'b0;
         m_owner       <= 0;
         m_last        <= 1'b1;
         m_rom_addr    <= 3'd0;
         m_rsp_data[0] <= 8'd0;
         m_rsp_data[1] <= 8'd0;
      end else if (m_busy) begin
         m_rsp_data[m_owner]  <= rom[m_rom_addr];
         m_rsp_valid[m_owner] <= 1'b1;
         m_busy               <= 1'b0;
      end else if (m_win >= 0) begin
         m_rom_addr <= (m_win == 1) ? req1_addr : req0_addr;
         m_owner    <= m_win;
         m_last     <= (m_win == 1);
         m_busy     <= 1'b1;
         acc0       <= (m_win == 0);
         acc1       <= (m_win == 1);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("mdl_req0_ready", 32'(req0_ready), 32'(m_win == 0));
         chk("mdl_req1_ready", 32'(req1_ready), 32'(m_win == 1));
         chk("mdl_busy", 32'(busy), 32'(m_busy));
         chk("mdl_rsp0_valid", 32'(rsp0_valid), 32'(m_rsp_valid[0]));
         chk("mdl_rsp1_valid", 32'(rsp1_valid), 32'(m_rsp_valid[1]));
         chk("mdl_rsp0_data", 32'(rsp0_data), 32'(m_rsp_data[0]));
         chk("mdl_rsp1_data", 32'(rsp1_data), 32'(m_rsp_data[1]));
         chk("mdl_rom_addr", 32'(rom_addr), 32'(m_rom_addr));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rom[0] = 8'hED; rom[1] = 8'hB7; rom[2] = 8'h3C; rom[3] = 8'hE7;
      rom[4] = 8'h51; rom[5] = 8'h96; rom[6] = 8'h0F; rom[7] = 8'hAA;

      do_reset();
      checking = 1'b1;

      // Reset values, then a single request from requester 0.
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_rsp0_data", 32'(rsp0_data), 32'd0);
      chk("rst_rsp1_data", 32'(rsp1_data), 32'd0);
      chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
      step();
      req0_valid = 1'b1; req0_addr = 3'd3;
      @(negedge clk);
      chk("r029_ready0", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("r029_busy", 32'(busy), 32'd1);
      chk("r029_rom_addr", 32'(rom_addr), 32'd3);
      step();
      @(negedge clk);
      chk("r029_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("r029_rsp0_data", 32'(rsp0_data), 32'hE7);
      chk("r029_rsp1_valid", 32'(rsp1_valid), 32'd0);
      step();
      @(negedge clk);
      chk("r029_pulse_end", 32'(rsp0_valid), 32'd0);
      chk("r029_data_hold", 32'(rsp0_data), 32'hE7);

      // Tie straight after reset: requester 0 first, then requester 1.
      do_reset();
      req0_valid = 1'b1; req0_addr = 3'd0;
      req1_valid = 1'b1; req1_addr = 3'd7;
      @(negedge clk);
      chk("r030_ready", 32'({req1_ready, req0_ready}), 32'b01);
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("r030_ready_read", 32'(req1_ready), 32'd0);
      step();
      @(negedge clk);
      chk("r030_rsp0_data", 32'(rsp0_data), 32'hED);
      chk("r030_ready1_overlap", 32'({req1_ready, rsp0_valid}), 32'b11);
      step();
      req1_valid = 1'b0;
      step();
      @(negedge clk);
      chk("r030_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("r030_rsp1_data", 32'(rsp1_data), 32'hAA);

      // Both held valid: grants alternate, one accept every two cycles.
      do_reset();
      req0_valid = 1'b1; req0_addr = 3'd2;
      req1_valid = 1'b1; req1_addr = 3'd5;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         chk("r031_grant", 32'({req1_ready, req0_ready}),
             (c % 2 == 1) ? 32'd0 : (((c / 2) % 2 == 0) ? 32'd1 : 32'd2));
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Requester 1 alone, back to back.
      do_reset();
      req1_valid = 1'b1; req1_addr = 3'd1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("r032_ready1", 32'({req0_ready, req1_ready}), 32'(c % 2 == 0));
         chk("r032_busy", 32'(busy), 32'(c % 2 == 1));
         if (c >= 2 && c % 2 == 0)
            chk("r032_rsp1", 32'({rsp1_valid, rsp1_data}), 32'h1B7);
         step();
      end
      req1_valid = 1'b0;

      // Reset during READ aborts the read.
      do_reset();
      req0_valid = 1'b1; req0_addr = 3'd7;
      @(negedge clk);
      chk("r033_ready0", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("r033_in_read", 32'(busy), 32'd1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("r033_no_pulse", 32'({rsp1_valid, rsp0_valid, busy}), 32'd0);
      chk("r033_data", 32'({rsp1_data, rsp0_data}), 32'd0);
      chk("r033_rom_addr", 32'(rom_addr), 32'd0);
      step();
      req0_valid = 1'b1; req0_addr = 3'd0;
      req1_valid = 1'b1; req1_addr = 3'd1;
      @(negedge clk);
      chk("r033_tie", 32'({req1_ready, req0_ready}), 32'b01);
      step();
      req0_valid = 1'b0;
      step();
      @(negedge clk);
      chk("r033_rsp0", 32'({rsp0_valid, rsp0_data}), 32'h1ED);
      step();
      req1_valid = 1'b0;
      step();

      // Random traffic; requesters hold valid/addr until accepted.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_addr  = 3'($urandom_range(0, 7));
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_addr  = 3'($urandom_range(0, 7));
         end
         step();
      end
      rst = 1'b0;
      step();
      checking = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
